output_port_arbiter: RTL and testbench
======================================

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of input FIFOs sharing the output link.
REQ-002 Parameter DATA_W, default 8: FIFO word / flit width in bits.
REQ-003 Parameter LEN_W, default 4: header length field width; header[LEN_W-1:0] is the payload flit count.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rempty  input  NUM_PORTS  per-FIFO empty flag from each FIFO read side.
REQ-007 rdata  input  NUM_PORTS*DATA_W  per-FIFO head word; port k occupies bits [k*DATA_W +: DATA_W]; valid whenever rempty[k]=0 (show-ahead).
REQ-008 rinc  output  NUM_PORTS  per-FIFO one-cycle pop strobe.
REQ-009 out_data  output  DATA_W  flit to the output link.
REQ-010 out_valid  output  1  out_data holds a valid flit.
REQ-011 out_ready  input  1  downstream accepts the flit this cycle.
REQ-012 grant  output  NUM_PORTS  one-hot owner of the link; all zero when idle.
REQ-013 busy  output  1  high while a packet is in progress.

Function
REQ-014 FSM states: IDLE, HEADER, PAYLOAD.
REQ-015 IDLE: when any rempty[k]=0, register a one-hot grant for the first non-empty port searched round-robin from last_grant+1 (mod NUM_PORTS), then go to HEADER; otherwise stay in IDLE.
REQ-016 Arbitration latency: one cycle from the first non-empty flag to grant assertion; no flit moves in the IDLE cycle.
REQ-017 HEADER/PAYLOAD: out_valid = !rempty[g] and out_data = rdata[g], where g is the granted port; otherwise out_valid=0 and out_data=0.
REQ-018 Transfer occurs when out_valid & out_ready; only then rinc[g]=1 for that cycle; rinc of non-granted ports is always 0.
REQ-019 HEADER transfer: load remaining <= header[LEN_W-1:0]; if the field is 0, go to IDLE; otherwise go to PAYLOAD.
REQ-020 PAYLOAD transfer: decrement remaining; the transfer with remaining=1 ends the packet and returns the FSM to IDLE.
REQ-021 On packet end: last_grant <= g; grant clears on the same edge.
REQ-022 Grant is held for the whole packet; flits from different ports never interleave.
REQ-023 FIFO empty mid-packet: out_valid=0 and rinc=0; wait indefinitely with grant held; no timeout.
REQ-024 out_ready low with out_valid high: out_data is held stable and no pop occurs.
REQ-025 Maximum packet is 1 + (2^LEN_W - 1) flits; the counter is LEN_W bits and never underflows.
REQ-026 busy = (state != IDLE).
REQ-027 A new arbitration happens only in IDLE; back-to-back packets therefore have one idle cycle between them.

Reset
REQ-028 While rst is high: state=IDLE, grant=0, remaining=0, last_grant=NUM_PORTS-1 (port 0 has first priority), rinc=0, out_valid=0, out_data=0, busy=0.
REQ-029 Reset mid-packet abandons the packet; no pop or flit is emitted in the reset cycle, and the first grant after deassertion follows REQ-015.

Structure
REQ-030 Shared package router_pkg holds NUM_PORTS, DATA_W and LEN_W defaults, and the FSM state encoding (2 bits: IDLE=00, HEADER=01, PAYLOAD=10).
REQ-031 Round-robin selection is a combinational sub-module rr_priority_select (inputs: request vector, last_grant index; output: one-hot next grant), instantiated once.

Verification
REQ-032 Single port: port 2 holds header 0x03 plus payload A,B,C, out_ready=1 -> grant=0100 one cycle later; out_data sequence 03,A,B,C on 4 consecutive cycles; exactly 4 rinc[2] pulses; busy drops after C.
REQ-033 Fairness: all 4 ports hold 1-flit packets (header 0x00), after reset -> grant order 0,1,2,3,0; each grant lasts 1 cycle, separated by 1 idle cycle.
REQ-034 Backpressure: header 0x02, out_ready low for 3 cycles at payload flit 1 -> out_valid stays high with stable data; no rinc during the stall; 3 pops total.
REQ-035 Underflow stall: port 1 FIFO goes empty after header 0x02 and the first payload flit -> out_valid=0, grant held at 0010; the packet completes when the second payload flit arrives 5 cycles later.
REQ-036 Reset mid-packet: rst pulsed during PAYLOAD of port 3 -> all outputs zero asynchronously; the next grant goes to the lowest-index non-empty port.
REQ-037 Max length: header 0x0F -> 16 flits forwarded, the counter reaches 0 without wrapping, FSM returns to IDLE.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared size defaults and FSM encoding for the output port arbiter.
package router_pkg;
   localparam int NUM_PORTS_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int LEN_W_DEF = 4;
   typedef enum logic [1:0] {IDLE = 2'b00, HEADER = 2'b01, PAYLOAD = 2'b10} state_t;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: one-hot pick of the first requester after last, wrapping round.
module rr_priority_select #(
   parameter int N = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt
);
   logic [IW-1:0] idx;
   logic found;
   always_comb begin
      gnt = '0;
      found = 1'b0;
      idx = '0;
      for (int i = 1; i <= N; i++) begin
         idx = IW'((int'(last) + i) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin packet arbiter forwarding length-prefixed
// packets from show-ahead FIFOs onto one output link.
module output_port_arbiter
   import router_pkg::*;
#(
   parameter int NUM_PORTS = NUM_PORTS_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        rempty,
   input  logic [NUM_PORTS*DATA_W-1:0] rdata,
   output logic [NUM_PORTS-1:0]        rinc,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_PORTS-1:0]        grant,
   output logic                        busy
);
   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   state_t state, state_n;
   logic [NUM_PORTS-1:0] grant_n, next_gnt;
   logic [LEN_W-1:0] remaining, remaining_n;
   logic [IW-1:0] last_grant, last_grant_n, gi;
   logic [DATA_W-1:0] cur_data;
   logic xfer;

   rr_priority_select #(.N(NUM_PORTS), .IW(IW)) u_rr (
      .req(~rempty),
      .last(last_grant),
      .gnt(next_gnt)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         remaining <= '0;
         last_grant <= IW'(NUM_PORTS - 1);
      end else begin
         state <= state_n;
         grant <= grant_n;
         remaining <= remaining_n;
         last_grant <= last_grant_n;
      end

   // grant is zero outside a packet, so the mux alone zeroes out_data when idle
   always_comb begin
      cur_data = '0;
      gi = '0;
      for (int k = 0; k < NUM_PORTS; k++)
         if (grant[k]) begin
            cur_data = rdata[k*DATA_W +: DATA_W];
            gi = IW'(k);
         end
   end

   assign busy = state != IDLE;
   assign out_valid = busy && ((grant & ~rempty) != '0);
   assign out_data = cur_data;
   assign xfer = out_valid && out_ready;
   assign rinc = xfer ? grant : '0;

   always_comb begin
      state_n = state;
      grant_n = grant;
      remaining_n = remaining;
      last_grant_n = last_grant;
      case (state)
         IDLE:
            if (~rempty != '0) begin
               state_n = HEADER;
               grant_n = next_gnt;
            end
         HEADER:
            if (xfer) begin
               remaining_n = cur_data[LEN_W-1:0];
               state_n = PAYLOAD;
               if (cur_data[LEN_W-1:0] == '0) begin
                  state_n = IDLE;
                  grant_n = '0;
                  last_grant_n = gi;
               end
            end
         PAYLOAD:
            if (xfer) begin
               remaining_n = remaining - LEN_W'(1);
               if (remaining == LEN_W'(1)) begin
                  state_n = IDLE;
                  grant_n = '0;
                  last_grant_n = gi;
               end
            end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed and randomized checks of the arbiter against
// a packet-level model built on per-port byte queues.
module tb_output_port_arbiter;
   localparam int NP = 4;
   localparam int DW = 8;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic rst;
   logic [NP-1:0] rempty, rinc, grant;
   logic [NP*DW-1:0] rdata;
   logic [DW-1:0] out_data;
   logic out_valid, out_ready, busy;

   output_port_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [7:0] fifo[NP][$];
   logic [7:0] src[NP][$];
   int vectors = 0, miscompares = 0;
   bit chk = 1'b0;
   int m_owner = -1, m_left = -1, m_last = NP - 1, pop_port = -1, nxt;
   int dut_pops[NP];
   int rdy_force = 1, feed_pct = 0, base, len, p;
   logic [NP-1:0] eg;
   logic ev;
   logic [7:0] ed, hdr;
   logic [3:0] fair[9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                           4'b0000, 4'b1000, 4'b0000, 4'b0001};

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void drive();
      for (int k = 0; k < NP; k++) begin
         rempty[k] = fifo[k].size() == 0;
         rdata[k*DW +: DW] = fifo[k].size() > 0 ? fifo[k][0] : 8'($urandom);
      end
   endfunction

   // model: owner of the link, payload flits still owed (-1 = header next), last owner
   always @(negedge clk) begin
      for (int k = 0; k < NP; k++) if (rinc[k] === 1'b1) dut_pops[k]++;
      if (chk) begin
         eg = m_owner >= 0 ? NP'(1 << m_owner) : '0;
         ev = m_owner >= 0 && fifo[m_owner].size() > 0;
         ed = ev ? fifo[m_owner][0] : 8'h00;
         check("grant", 32'(grant), 32'(eg));
         check("busy", 32'(busy), 32'(m_owner >= 0));
         check("out_valid", 32'(out_valid), 32'(ev));
         check("rinc", 32'(rinc), 32'((ev && out_ready) ? eg : '0));
         if (ev || m_owner < 0) check("out_data", 32'(out_data), 32'(ed));
         if (m_owner < 0) begin
            nxt = -1;
            for (int i = 1; i <= NP; i++)
               if (nxt < 0 && fifo[(m_last + i) % NP].size() > 0) nxt = (m_last + i) % NP;
            m_owner = nxt;
         end else if (ev && out_ready) begin
            pop_port = m_owner;
            if (m_left < 0) m_left = int'(ed[LW-1:0]);
            else m_left--;
            if (m_left == 0) begin
               m_last = m_owner;
               m_owner = -1;
               m_left = -1;
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      if (pop_port >= 0) begin
         void'(fifo[pop_port].pop_front());
         pop_port = -1;
      end
      for (int k = 0; k < NP; k++)
         if (src[k].size() > 0 && $urandom_range(99) < feed_pct) fifo[k].push_back(src[k].pop_front());
      out_ready = rdy_force >= 0 ? rdy_force[0] : ($urandom_range(99) < 75);
      drive();
      #1;
   endtask

   task automatic do_reset();
      chk = 1'b0;
      rst = 1'b1;
      for (int k = 0; k < NP; k++) begin
         fifo[k].delete();
         src[k].delete();
      end
      pop_port = -1;
      drive();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      m_owner = -1;
      m_left = -1;
      m_last = NP - 1;
      chk = 1'b1;
   endtask

   initial begin
      bit done;
      rst = 1'b1;
      out_ready = 1'b1;
      rdata = '0;
      for (int k = 0; k < NP; k++) dut_pops[k] = 0;
      fifo[1].push_back(8'h00);
      drive();
      #3;
      check("rst_grant", 32'(grant), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_valid", 32'(out_valid), 32'(0));
      check("rst_rinc", 32'(rinc), 32'(0));
      check("rst_data", 32'(out_data), 32'(0));
      do_reset();

      // single port 2 packet: 03 A1 B2 C3
      fifo[2].push_back(8'h03); fifo[2].push_back(8'hA1);
      fifo[2].push_back(8'hB2); fifo[2].push_back(8'hC3);
      drive(); #1;
      base = dut_pops[2];
      check("sp_idle_grant", 32'(grant), 32'(0));
      check("sp_idle_rinc", 32'(rinc), 32'(0));
      cycle();
      check("sp_grant", 32'(grant), 32'(4'b0100));
      check("sp_hdr", 32'(out_data), 32'(8'h03));
      cycle(); check("sp_a", 32'(out_data), 32'(8'hA1));
      cycle(); check("sp_b", 32'(out_data), 32'(8'hB2));
      cycle(); check("sp_c", 32'(out_data), 32'(8'hC3));
      check("sp_busy_c", 32'(busy), 32'(1));
      cycle(); check("sp_busy_end", 32'(busy), 32'(0));
      check("sp_pops", 32'(dut_pops[2] - base), 32'(4));

      // fairness: 1-flit packets on every port, port 0 twice
      do_reset();
      fifo[0].push_back(8'h00); fifo[0].push_back(8'h00);
      for (int k = 1; k < NP; k++) fifo[k].push_back(8'h00);
      drive(); #1;
      for (int i = 0; i < 9; i++) begin
         cycle();
         check($sformatf("fair_grant%0d", i), 32'(grant), 32'(fair[i]));
      end

      // backpressure on the first payload flit
      do_reset();
      fifo[0].push_back(8'h02); fifo[0].push_back(8'h11); fifo[0].push_back(8'h22);
      drive(); #1;
      base = dut_pops[0];
      cycle(); check("bp_hdr", 32'(out_data), 32'(8'h02));
      rdy_force = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("bp_valid", 32'(out_valid), 32'(1));
         check("bp_data", 32'(out_data), 32'(8'h11));
         check("bp_rinc", 32'(rinc), 32'(0));
      end
      rdy_force = 1;
      cycle(); check("bp_go", 32'(rinc), 32'(4'b0001));
      cycle(); check("bp_p2", 32'(out_data), 32'(8'h22));
      cycle(); check("bp_pops", 32'(dut_pops[0] - base), 32'(3));

      // port 1 FIFO runs dry mid-packet
      do_reset();
      fifo[1].push_back(8'h02); fifo[1].push_back(8'h5A);
      drive(); #1;
      cycle(); check("uf_grant", 32'(grant), 32'(4'b0010));
      cycle(); check("uf_p1", 32'(out_data), 32'(8'h5A));
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("uf_valid", 32'(out_valid), 32'(0));
         check("uf_hold", 32'(grant), 32'(4'b0010));
      end
      fifo[1].push_back(8'h6B);
      drive(); #1;
      check("uf_p2", 32'(out_data), 32'(8'h6B));
      cycle(); check("uf_done", 32'(busy), 32'(0));

      // reset during a port 3 payload
      do_reset();
      fifo[3].push_back(8'h05);
      for (int i = 1; i <= 5; i++) fifo[3].push_back(8'(i));
      drive(); #1;
      cycle(); check("mr_grant", 32'(grant), 32'(4'b1000));
      cycle(); cycle(); check("mr_p2", 32'(out_data), 32'(8'h02));
      chk = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("mr_grant0", 32'(grant), 32'(0));
      check("mr_busy0", 32'(busy), 32'(0));
      check("mr_valid0", 32'(out_valid), 32'(0));
      check("mr_rinc0", 32'(rinc), 32'(0));
      check("mr_data0", 32'(out_data), 32'(0));
      do_reset();
      fifo[1].push_back(8'h00); fifo[3].push_back(8'h00);
      drive(); #1;
      cycle(); check("mr_regrant", 32'(grant), 32'(4'b0010));

      // maximum length packet
      do_reset();
      fifo[0].push_back(8'h0F);
      for (int i = 0; i < 15; i++) fifo[0].push_back(8'(8'h40 + i));
      drive(); #1;
      base = dut_pops[0];
      for (int i = 1; i <= 17; i++) begin
         cycle();
         if (i == 1) check("ml_hdr", 32'(out_data), 32'(8'h0F));
         if (i == 16) begin
            check("ml_last", 32'(out_data), 32'(8'h4E));
            check("ml_busy", 32'(busy), 32'(1));
         end
      end
      check("ml_idle", 32'(busy), 32'(0));
      check("ml_pops", 32'(dut_pops[0] - base), 32'(16));

      // randomized traffic with trickling FIFOs and random backpressure
      do_reset();
      rdy_force = -1;
      feed_pct = 60;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(9) == 0) begin
            p = $urandom_range(NP - 1);
            if (src[p].size() < 40) begin
               len = $urandom_range(3) == 0 ? $urandom_range(15) : $urandom_range(3);
               hdr = {4'($urandom), 4'(len)};
               src[p].push_back(hdr);
               for (int j = 0; j < len; j++) src[p].push_back(8'($urandom));
            end
         end
         cycle();
      end
      done = 1'b0;
      for (int c = 0; c < 5000 && !done; c++) begin
         cycle();
         done = m_owner < 0;
         for (int k = 0; k < NP; k++) if (src[k].size() > 0 || fifo[k].size() > 0) done = 1'b0;
      end
      check("drain_timeout", 32'(done), 32'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
